// File: rtl/uart_pkg.sv
// Shared types, constants and the baud divisor helper for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int IDLE_BITS = 10;

  // Rounded clk/(baud*os), never below one clock per tick.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int d;
    d = (clk_hz + (baud * os) / 2) / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Serial line plus received-byte outputs shared by the deserializer and its consumer.
interface uart_rx_deserializer_if;

  logic       RxD;
  logic       RxD_data_ready;
  logic [7:0] RxD_data;
  logic       RxD_frame_err;
  logic       RxD_idle;
  logic       RxD_endofpacket;

  modport master (
    output RxD,
    input  RxD_data_ready, RxD_data, RxD_frame_err, RxD_idle, RxD_endofpacket
  );

  modport slave (
    input  RxD,
    output RxD_data_ready, RxD_data, RxD_frame_err, RxD_idle, RxD_endofpacket
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock oversampling tick every DIV clocks.
module uart_baud_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Divider counter wrapping at DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1 oversampling receiver: synchronizes and filters RxD, frames bytes, flags stop-bit
// errors and reports line idle / end-of-packet for the LCD driver downstream.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  uart_rx_deserializer_if.slave bus
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int PW  = $clog2(OVERSAMPLE);
  localparam int GW  = $clog2(IDLE_BITS * OVERSAMPLE + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] PH_MID   = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [GW-1:0] GAP_SAT  = GW'(IDLE_BITS * OVERSAMPLE);
  localparam logic [GW-1:0] GAP_PRE  = GW'(IDLE_BITS * OVERSAMPLE - 1);

  logic            w_tick;
  logic            w_rx_f;
  logic [1:0]      r_sync;
  logic [2:0]      r_maj;
  rx_state_t       r_state;
  logic [PW-1:0]   r_phase;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shreg;
  logic [7:0]      r_data;
  logic            r_ready;
  logic            r_ferr;
  logic [GW-1:0]   r_gap;
  logic            r_idle;
  logic            r_eop;
  logic            r_got_byte;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_tick)
  );

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], bus.RxD};
    end
  end

  // Three most recent tick samples feed the majority vote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_maj <= 3'b111;
    end else if (w_tick) begin
      r_maj <= {r_maj[1:0], r_sync[1]};
    end else begin
      r_maj <= r_maj;
    end
  end

  assign w_rx_f = (r_maj[0] & r_maj[1]) | (r_maj[0] & r_maj[2]) | (r_maj[1] & r_maj[2]);

  // Frame FSM; ready and frame_err come from different STOP branches so never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_phase  <= '0;
      r_bitcnt <= 3'd0;
      r_shreg  <= 8'h00;
      r_data   <= 8'h00;
      r_ready  <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
      if (w_tick) begin
        case (r_state)
          IDLE: begin
            if (!w_rx_f) begin
              r_state <= START;
              r_phase <= '0;
            end
          end
          START: begin
            if (r_phase == PH_MID) begin
              r_phase  <= '0;
              r_bitcnt <= 3'd0;
              r_state  <= w_rx_f ? IDLE : DATA;
            end else begin
              r_phase <= r_phase + PW'(1);
            end
          end
          DATA: begin
            if (r_phase == PH_LAST) begin
              r_phase  <= '0;
              r_shreg  <= {w_rx_f, r_shreg[7:1]};
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_state <= STOP;
              end
            end else begin
              r_phase <= r_phase + PW'(1);
            end
          end
          STOP: begin
            if (r_phase == PH_LAST) begin
              r_phase <= '0;
              if (w_rx_f) begin
                r_data  <= r_shreg;
                r_ready <= 1'b1;
                r_state <= IDLE;
              end else begin
                r_ferr  <= 1'b1;
                r_state <= BREAK;
              end
            end else begin
              r_phase <= r_phase + PW'(1);
            end
          end
          BREAK: begin
            if (w_rx_f) begin
              r_state <= IDLE;
            end
          end
          default: begin
            r_state <= IDLE;
            r_phase <= '0;
          end
        endcase
      end
    end
  end

  // Idle gap counter and end-of-packet pulse; eop needs a byte since the last pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap      <= '0;
      r_idle     <= 1'b1;
      r_eop      <= 1'b0;
      r_got_byte <= 1'b0;
    end else begin
      r_eop <= 1'b0;
      if (r_ready) begin
        r_got_byte <= 1'b1;
      end
      if (w_tick) begin
        if ((r_state == IDLE) && w_rx_f) begin
          if (r_gap != GAP_SAT) begin
            r_gap <= r_gap + GW'(1);
          end
          if (r_gap == GAP_PRE) begin
            r_idle <= 1'b1;
            if (!r_idle && r_got_byte) begin
              r_eop      <= 1'b1;
              r_got_byte <= 1'b0;
            end
          end
        end else begin
          r_gap  <= '0;
          r_idle <= 1'b0;
        end
      end
    end
  end

  assign bus.RxD_data_ready  = r_ready;
  assign bus.RxD_data        = r_data;
  assign bus.RxD_frame_err   = r_ferr;
  assign bus.RxD_idle        = r_idle;
  assign bus.RxD_endofpacket = r_eop;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench: frame-level reference model plus directed and random serial traffic.
module tb_uart_rx_deserializer;

  localparam int CLK_FREQ = 7_372_800;
  localparam int BAUD     = 115200;
  localparam int OS       = 16;
  localparam int BIT_CLK  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_deserializer_if bus();

  uart_rx_deserializer #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: bytes owed (with the cycle their start edge was driven) and counters.
  logic [7:0] exp_q[$];
  int         exp_t[$];
  logic [7:0] m_data     = 8'h00;
  int         exp_ferr   = 0;
  int         got_ferr   = 0;
  int         n_ready    = 0;
  int         n_eop      = 0;
  int         since_eop  = 0;
  int         last_ready = -100000;
  int         last_gap   = 0;
  int         t_start    = 0;
  logic       prev_idle  = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    bus.RxD = v;
    wait_clk(BIT_CLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    if (stop) begin
      exp_q.push_back(b);
      exp_t.push_back(cyc);
    end else begin
      exp_ferr++;
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic start_reset();
    rst_n = 1'b0;
    exp_q.delete();
    exp_t.delete();
    m_data     = 8'h00;
    since_eop  = 0;
    last_ready = -100000;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 2000) begin
      wait_clk(1);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Per-cycle compare of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("ready_ferr_excl", int'(bus.RxD_data_ready & bus.RxD_frame_err), 0);
      if (bus.RxD_data_ready) begin
        n_ready++;
        since_eop++;
        check("ready_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          m_data  = exp_q.pop_front();
          t_start = exp_t.pop_front();
          check("ready_latency", int'((cyc - t_start >= 608) && (cyc - t_start <= 640)), 1);
          check("ready_spacing", int'(cyc - last_ready >= 608), 1);
          last_gap   = cyc - last_ready;
          last_ready = cyc;
        end
      end
      check("data_held", int'(bus.RxD_data), int'(m_data));
      if (bus.RxD_frame_err) got_ferr++;
      check("eop_rule", int'(bus.RxD_endofpacket),
            int'(bus.RxD_idle && !prev_idle && (since_eop > 0)));
      if (bus.RxD_endofpacket) begin
        n_eop++;
        since_eop = 0;
      end
      prev_idle = bus.RxD_idle;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int base;
    int base_ferr;
    int gap;
    logic [7:0] rb;
    logic       rs;

    bus.RxD = 1'b1;
    start_reset();
    wait_clk(3);
    check("rst_ready", int'(bus.RxD_data_ready), 0);
    check("rst_data", int'(bus.RxD_data), 32'h0);
    check("rst_ferr", int'(bus.RxD_frame_err), 0);
    check("rst_idle", int'(bus.RxD_idle), 1);
    check("rst_eop", int'(bus.RxD_endofpacket), 0);
    rst_n = 1'b1;

    // Idle after reset with no bytes must not produce end-of-packet.
    wait_clk(12 * BIT_CLK);
    check("idle_no_byte_eop", n_eop, 0);
    check("idle_no_byte_idle", int'(bus.RxD_idle), 1);

    // Single good byte.
    send_byte(8'h41, 1'b1);
    wait_clk(BIT_CLK);
    drain("t1_drain");
    check("t1_data", int'(bus.RxD_data), 32'h41);
    check("t1_ready_cnt", n_ready, 1);
    check("t1_ferr", got_ferr, 0);

    // Short start glitch is rejected.
    wait_clk(2 * BIT_CLK);
    base = n_ready;
    bus.RxD = 1'b0;
    wait_clk(12);
    bus.RxD = 1'b1;
    wait_clk(3 * BIT_CLK);
    check("t2_no_ready", n_ready, base);
    check("t2_no_ferr", got_ferr, 0);
    check("t2_data", int'(bus.RxD_data), 32'h41);

    // Bad stop bit then a long break yields exactly one frame error.
    send_byte(8'h41, 1'b1);
    send_byte(8'h55, 1'b0);
    wait_clk(40 * BIT_CLK);
    bus.RxD = 1'b1;
    wait_clk(3 * BIT_CLK);
    check("t3_ferr_once", got_ferr, 1);
    check("t3_data_kept", int'(bus.RxD_data), 32'h41);
    send_byte(8'h33, 1'b1);
    wait_clk(BIT_CLK);
    drain("t3_drain");
    check("t3_data_new", int'(bus.RxD_data), 32'h33);

    // Back-to-back frames with zero gap.
    wait_clk(2 * BIT_CLK);
    send_byte(8'h80, 1'b1);
    send_byte(8'h7F, 1'b1);
    wait_clk(BIT_CLK);
    drain("t4_drain");
    check("t4_gap", last_gap, 640);
    check("t4_data", int'(bus.RxD_data), 32'h7F);

    // Reset during data bit 4 of 0xAA discards the partial byte.
    wait_clk(2 * BIT_CLK);
    base = n_ready;
    rb = 8'hAA;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(rb[i]);
    bus.RxD = rb[4];
    wait_clk(BIT_CLK / 2);
    start_reset();
    wait_clk(BIT_CLK / 2);
    for (int i = 5; i < 8; i++) drive_bit(rb[i]);
    drive_bit(1'b1);
    wait_clk(BIT_CLK);
    rst_n = 1'b1;
    wait_clk(2 * BIT_CLK);
    check("t5_data_zero", int'(bus.RxD_data), 32'h0);
    check("t5_no_ready", n_ready, base);
    send_byte(8'hC3, 1'b1);
    wait_clk(BIT_CLK);
    drain("t5_drain");
    check("t5_data", int'(bus.RxD_data), 32'hC3);
    check("t5_ready_cnt", n_ready, base + 1);

    // Idle detection and a single end-of-packet pulse.
    wait_clk(12 * BIT_CLK);
    base = n_eop;
    send_byte(8'h01, 1'b1);
    wait_clk(12 * BIT_CLK);
    check("t6_eop_once", n_eop, base + 1);
    check("t6_idle", int'(bus.RxD_idle), 1);
    check("t6_data", int'(bus.RxD_data), 32'h01);
    wait_clk(12 * BIT_CLK);
    check("t6_no_second_eop", n_eop, base + 1);

    // Random traffic with occasional bad stop bits and random gaps.
    base_ferr = got_ferr - exp_ferr;
    for (int n = 0; n < 30; n++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 5) != 0);
      send_byte(rb, rs);
      gap = $urandom_range(0, 2) * BIT_CLK + $urandom_range(0, 63);
      if (!rs) gap = gap + BIT_CLK;
      if (gap > 0) begin
        bus.RxD = 1'b1;
        wait_clk(gap);
      end
      bus.RxD = 1'b1;
    end
    wait_clk(2 * BIT_CLK);
    drain("rand_drain");
    check("rand_ferr", got_ferr - exp_ferr, base_ferr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
